// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
// The state encoding is visible on the debug port, so it is fixed here.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    PLL_RST   = 2'd3
  } state_e;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer.
// Synchronous active-low reset clears both flops to 0.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies PLL lock into a debounced system reset.
// Requests a PLL reset on lock timeout and tracks lock-loss diagnostics.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int LOCK_CYCLES    = 4096,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOSS_W         = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              lock,
  output logic              pll_rst,
  output logic              sys_rst_n,
  output logic              locked_o,
  output logic              timeout,
  output logic [LOSS_W-1:0] loss_count,
  output logic [1:0]        state_o
);

  localparam int CW = cnt_width(
    LOCK_CYCLES, TIMEOUT_CYCLES, PLL_RST_CYCLES);

  localparam logic [CW-1:0] LOCK_TC = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] TO_TC   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] PR_TC   = CW'(PLL_RST_CYCLES - 1);

  logic              lock_s;
  state_e            state;
  state_e            state_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              timeout_nxt;
  logic [LOSS_W-1:0] loss_nxt;

  sync_2ff u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (lock),
    .q       (lock_s)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_nxt = timeout;
    loss_nxt    = loss_count;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TO_TC) begin
          state_nxt   = PLL_RST;
          cnt_nxt     = '0;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == LOCK_TC) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
          if (loss_count != '1)
            loss_nxt = loss_count + LOSS_W'(1);
        end
      end
      PLL_RST: begin
        // lock_s is deliberately ignored while the PLL is held in reset
        if (cnt == PR_TC) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      sys_rst_n  <= 1'b0;
      pll_rst    <= 1'b0;
      timeout    <= 1'b0;
      loss_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sys_rst_n  <= (state_nxt == RUN);
      pll_rst    <= (state_nxt == PLL_RST);
      timeout    <= timeout_nxt;
      loss_count <= loss_nxt;
    end
  end

  assign locked_o = lock_s;
  assign state_o  = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and random checks of pll_lock_supervisor against a
// timestamp-based model of lock qualification and timeout.
module tb_pll_lock_supervisor;

  localparam int L = 8;
  localparam int T = 32;
  localparam int P = 4;
  localparam int W = 2;

  localparam int M_WAIT = 0;
  localparam int M_STAB = 1;
  localparam int M_RUN  = 2;
  localparam int M_PRST = 3;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         lock    = 1'b0;
  logic         pll_rst;
  logic         sys_rst_n;
  logic         locked_o;
  logic         timeout;
  logic [W-1:0] loss_count;
  logic [1:0]   state_o;

  int compared   = 0;
  int mismatched = 0;

  int n     = 0;
  int mode  = M_WAIT;
  int t0    = 0;
  int mloss = 0;
  bit ms1   = 1'b0;
  bit mls   = 1'b0;
  bit mto   = 1'b0;

  pll_lock_supervisor #(
    .LOCK_CYCLES    (L),
    .TIMEOUT_CYCLES (T),
    .PLL_RST_CYCLES (P),
    .LOSS_W         (W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .lock       (lock),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .locked_o   (locked_o),
    .timeout    (timeout),
    .loss_count (loss_count),
    .state_o    (state_o)
  );

  always #20 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Model: each mode remembers the cycle it was entered (t0);
  // transitions fire when the elapsed time reaches the limit.
  task automatic model_edge();
    bit ls_old;
    n++;
    if (!reset_n) begin
      ms1   = 1'b0;
      mls   = 1'b0;
      mode  = M_WAIT;
      t0    = n;
      mto   = 1'b0;
      mloss = 0;
      return;
    end
    ls_old = mls;
    mls    = ms1;
    ms1    = lock;
    case (mode)
      M_PRST: begin
        if (n - t0 == P) begin
          mode = M_WAIT;
          t0   = n;
        end
      end
      M_RUN: begin
        if (!ls_old) begin
          if (mloss < (1 << W) - 1) mloss++;
          mode = M_WAIT;
          t0   = n;
        end
      end
      M_STAB: begin
        if (!ls_old) begin
          mode = M_WAIT;
          t0   = n;
        end else if (n - t0 == L) begin
          mode = M_RUN;
        end
      end
      default: begin
        if (ls_old) begin
          mode = M_STAB;
          t0   = n;
        end else if (n - t0 == T) begin
          mode = M_PRST;
          t0   = n;
          mto  = 1'b1;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("sys_rst_n", sys_rst_n, mode == M_RUN);
    check("pll_rst", pll_rst, mode == M_PRST);
    check("locked_o", locked_o, mls);
    check("timeout", timeout, mto);
    check("loss_count", loss_count, mloss);
    check("state_o", state_o, mode);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // reset values and clean lock
    lock = 1'b0;
    do_reset();
    check("rst_state", state_o, 0);
    check("rst_sys", sys_rst_n, 0);
    check("rst_pll", pll_rst, 0);
    check("rst_loss", loss_count, 0);
    lock = 1'b1;
    repeat (10) tick();
    check("clean_pre", sys_rst_n, 0);
    tick();
    check("clean_rise", sys_rst_n, 1);
    check("clean_state", state_o, 2);
    check("clean_pll", pll_rst, 0);

    // one-cycle glitch during STABLE
    lock = 1'b0;
    do_reset();
    lock = 1'b1;
    repeat (5) tick();
    lock = 1'b0;
    tick();
    lock = 1'b1;
    repeat (2) tick();
    check("glitch_restart", state_o, 0);
    repeat (8) tick();
    check("glitch_pre", sys_rst_n, 0);
    tick();
    check("glitch_rise", sys_rst_n, 1);

    // lock timeout and PLL reset pulse
    lock = 1'b0;
    do_reset();
    repeat (31) tick();
    check("to_pre", pll_rst, 0);
    tick();
    check("to_start", pll_rst, 1);
    check("to_flag", timeout, 1);
    repeat (3) tick();
    check("to_hold", pll_rst, 1);
    tick();
    check("to_end", pll_rst, 0);
    check("to_state", state_o, 0);
    repeat (20) tick();
    check("to_sticky", timeout, 1);

    // lock arriving on the timeout terminal count
    lock = 1'b0;
    do_reset();
    repeat (29) tick();
    lock = 1'b1;
    repeat (3) tick();
    check("term_state", state_o, 1);
    check("term_timeout", timeout, 0);
    check("term_pll", pll_rst, 0);
    repeat (10) tick();
    check("term_run", state_o, 2);

    // lock loss counting with saturation
    for (int k = 1; k <= 4; k++) begin
      lock = 1'b0;
      repeat (2) tick();
      check("loss_hold", sys_rst_n, 1);
      tick();
      check("loss_fall", sys_rst_n, 0);
      check("loss_cnt", loss_count, (k > 3) ? 3 : k);
      lock = 1'b1;
      repeat (12) tick();
      check("loss_rerun", state_o, 2);
    end

    // reset during PLL_RST
    lock = 1'b0;
    do_reset();
    repeat (34) tick();
    check("mid_prst", pll_rst, 1);
    reset_n = 1'b0;
    tick();
    check("midp_pll", pll_rst, 0);
    check("midp_sys", sys_rst_n, 0);
    check("midp_to", timeout, 0);
    check("midp_state", state_o, 0);
    reset_n = 1'b1;

    // reset during RUN
    lock = 1'b1;
    repeat (12) tick();
    lock = 1'b0;
    repeat (3) tick();
    lock = 1'b1;
    repeat (12) tick();
    check("midr_run", state_o, 2);
    check("midr_loss", loss_count, 1);
    reset_n = 1'b0;
    tick();
    check("midr_sys", sys_rst_n, 0);
    check("midr_loss0", loss_count, 0);
    check("midr_state", state_o, 0);
    check("midr_pll", pll_rst, 0);
    reset_n = 1'b1;

    // random lock runs with occasional resets
    for (int i = 0; i < 150; i++) begin
      lock = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 30) == 0) reset_n = 1'b0;
      repeat ($urandom_range(1, 45)) tick();
      reset_n = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
